alu_rs_scheduler: RTL and testbench
===================================

Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler in front of the combinational ALU.
- Buffers dispatched ALU/branch/jump micro-ops until their operands are available.
- Snoops two common-data-bus (CDB) broadcast ports to capture operand values as they are produced.
- Issues at most one ready entry per cycle into registered ALU operand/opcode outputs.

Parameters:
- RS_SIZE, 16, number of station entries (power of two, ≥2).
- ID_WIDTH, 32, data/immediate width.
- ROB_WIDTH, 4, ROB tag width; tag 0 means "no dependency / invalid".
- ADDR_WIDTH, 32, PC width.
- OP_WIDTH, 6, opcode width.
- NOP_OP, 0, opcode value meaning "no operation".

Ports:
- clk_in  in  1  clock; all state changes on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; when low, all state is frozen.
- dsp_valid_in  in  1  dispatch request.
- dsp_opcode_in  in  OP_WIDTH  opcode.
- dsp_vj_in, dsp_vk_in  in  ID_WIDTH  operand values; meaningful only when the matching tag is 0.
- dsp_qj_in, dsp_qk_in  in  ROB_WIDTH  producer tags; 0 means the operand is ready.
- dsp_a_in  in  ID_WIDTH  immediate.
- dsp_dest_in  in  ROB_WIDTH  destination ROB tag (never 0).
- dsp_pc_in  in  ADDR_WIDTH  instruction PC.
- cdb0_tag_in, cdb1_tag_in  in  ROB_WIDTH  broadcast tags; 0 means idle.
- cdb0_val_in, cdb1_val_in  in  ID_WIDTH  broadcast values.
- flush_in  in  1  misprediction flush from the ROB.
- rs_full_out  out  1  no free entry.
- rs_count_out  out  $clog2(RS_SIZE)+1  number of busy entries.
- alu_opcode_out  out  OP_WIDTH  issued opcode; NOP_OP when idle.
- alu_vj_out, alu_vk_out, alu_a_out  out  ID_WIDTH  issued operands.
- alu_dest_out  out  ROB_WIDTH  issued destination tag.
- alu_pc_out  out  ADDR_WIDTH  issued PC.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All entries become not busy; count=0.
  - alu_opcode_out=NOP_OP; all other alu_* outputs are 0.
- Per-entry state: busy, opcode, vj, vk, qj, qk, a, dest, pc.
- rdy_in=0: no register changes at all, outputs hold their values; dispatch and CDB inputs are ignored.
- Allocation:
  - A dispatch is accepted on the edge when dsp_valid_in=1 and rs_full_out=0.
  - It goes into the lowest-index non-busy entry, evaluated on pre-edge busy bits.
  - An entry freed by issue on the same edge is not reused until the next cycle.
  - Dispatch while full is silently dropped; the dispatcher must gate on rs_full_out.
- Wakeup:
  - On each edge, every busy entry with qj≠0 and qj equal to cdb0_tag or cdb1_tag loads vj from that bus and clears qj.
  - qk is handled the same way.
  - If both buses carry the same tag, cdb0 wins.
- Dispatch bypass:
  - If a dispatched qj/qk matches a same-cycle CDB tag, the entry is written with the bus value and the tag cleared.
  - This prevents lost wakeups.
- Selection:
  - An entry is ready when busy=1, qj=0 and qk=0, using registered state.
  - An entry woken on edge N is first selectable in the cycle after edge N.
  - The fixed-priority pick is the lowest-index ready entry.
- Issue (registered):
  - On the edge, the selected entry's fields are copied into the alu_* registers and its busy bit is cleared.
  - If no entry is ready, alu_opcode_out=NOP_OP, alu_dest_out=0 and the other fields are 0.
  - Latency: an operand-ready dispatch accepted on edge N appears on the alu_* outputs after edge N+1.
  - Each issued entry drives the outputs for exactly one cycle.
- Count: rs_count_out = previous count + accepted dispatch − issue; simultaneous dispatch and issue leaves it unchanged.
- rs_full_out = (rs_count_out == RS_SIZE), registered.
- Flush:
  - flush_in=1 (with rdy_in=1) clears all busy bits, sets count=0 and forces alu_opcode_out=NOP_OP, alu_dest_out=0.
  - Flush takes priority over a same-cycle dispatch, wakeup and issue; the dispatch is dropped.
- No combinational path from any input to any output.

Test Plan:
- Reset:
  - Stimulus: rst_in low mid-run, with 5 busy entries and an op being issued.
  - Required: alu_opcode_out=NOP_OP and count=0 immediately, without waiting for a clock edge.
  - Required: after rst_in returns high, nothing issues until a new dispatch.
- Ready dispatch:
  - Stimulus: dispatch ADD with qj=qk=0, vj=5, vk=7, dest=3 at edge N.
  - Required: after edge N+1, alu_opcode_out=ADD, vj=5, vk=7, dest=3.
  - Required: NOP_OP after edge N+2; count returns to 0.
- Wakeup and bypass:
  - Stimulus: dispatch with qj=4 while cdb1_tag=4, val=0xDEAD in the same cycle.
  - Required: the entry issues next cycle with vj=0xDEAD.
  - Stimulus: a second entry with qk=6, woken two cycles later.
  - Required: it issues exactly one cycle after its broadcast.
- Priority:
  - Stimulus: entries 2 and 9 both ready.
  - Required: entry 2 issues first, entry 9 the following cycle.
- Full:
  - Stimulus: 16 dispatches with qj=5 outstanding.
  - Required: rs_full_out=1 and count=16; a 17th dispatch is dropped.
  - Stimulus: broadcast tag 5.
  - Required: entries issue in index order 0..15, one per cycle.
- Flush and stall:
  - Stimulus: flush_in together with a dispatch and a ready entry.
  - Required: next cycle NOP_OP, count=0, rs_full_out=0.
  - Stimulus: rdy_in low for 3 cycles with CDB activity.
  - Required: no state change and the broadcasts are not captured.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers micro-ops, snoops two CDB ports
// and issues the lowest-index ready entry into registered ALU outputs.
module alu_rs_scheduler #(
  parameter int RS_SIZE    = 16,
  parameter int ID_WIDTH   = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 6,
  parameter int NOP_OP     = 0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dsp_valid_in,
  input  logic [OP_WIDTH-1:0]       dsp_opcode_in,
  input  logic [ID_WIDTH-1:0]       dsp_vj_in,
  input  logic [ID_WIDTH-1:0]       dsp_vk_in,
  input  logic [ROB_WIDTH-1:0]      dsp_qj_in,
  input  logic [ROB_WIDTH-1:0]      dsp_qk_in,
  input  logic [ID_WIDTH-1:0]       dsp_a_in,
  input  logic [ROB_WIDTH-1:0]      dsp_dest_in,
  input  logic [ADDR_WIDTH-1:0]     dsp_pc_in,
  input  logic [ROB_WIDTH-1:0]      cdb0_tag_in,
  input  logic [ID_WIDTH-1:0]       cdb0_val_in,
  input  logic [ROB_WIDTH-1:0]      cdb1_tag_in,
  input  logic [ID_WIDTH-1:0]       cdb1_val_in,
  input  logic                      flush_in,
  output logic                      rs_full_out,
  output logic [$clog2(RS_SIZE):0]  rs_count_out,
  output logic [OP_WIDTH-1:0]       alu_opcode_out,
  output logic [ID_WIDTH-1:0]       alu_vj_out,
  output logic [ID_WIDTH-1:0]       alu_vk_out,
  output logic [ID_WIDTH-1:0]       alu_a_out,
  output logic [ROB_WIDTH-1:0]      alu_dest_out,
  output logic [ADDR_WIDTH-1:0]     alu_pc_out
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;
  localparam logic [OP_WIDTH-1:0] NOP = OP_WIDTH'(NOP_OP);

  logic [RS_SIZE-1:0]    r_busy;
  logic [OP_WIDTH-1:0]   r_op   [RS_SIZE];
  logic [ID_WIDTH-1:0]   r_vj   [RS_SIZE];
  logic [ID_WIDTH-1:0]   r_vk   [RS_SIZE];
  logic [ROB_WIDTH-1:0]  r_qj   [RS_SIZE];
  logic [ROB_WIDTH-1:0]  r_qk   [RS_SIZE];
  logic [ID_WIDTH-1:0]   r_a    [RS_SIZE];
  logic [ROB_WIDTH-1:0]  r_dest [RS_SIZE];
  logic [ADDR_WIDTH-1:0] r_pc   [RS_SIZE];
  logic [CW-1:0]         r_count;

  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [ID_WIDTH-1:0]   r_alu_vj;
  logic [ID_WIDTH-1:0]   r_alu_vk;
  logic [ID_WIDTH-1:0]   r_alu_a;
  logic [ROB_WIDTH-1:0]  r_alu_dest;
  logic [ADDR_WIDTH-1:0] r_alu_pc;

  logic          w_sel_vld;
  logic [IW-1:0] w_sel;
  logic          w_free_vld;
  logic [IW-1:0] w_free;
  logic          w_full;
  logic          w_accept;

  // cdb0 is checked first so it wins when both buses carry the tag
  function automatic logic [ID_WIDTH-1:0] snoop_v(
    input logic [ROB_WIDTH-1:0] q,
    input logic [ID_WIDTH-1:0]  v);
    if (q != '0 && q == cdb0_tag_in)      snoop_v = cdb0_val_in;
    else if (q != '0 && q == cdb1_tag_in) snoop_v = cdb1_val_in;
    else                                  snoop_v = v;
  endfunction

  function automatic logic [ROB_WIDTH-1:0] snoop_q(
    input logic [ROB_WIDTH-1:0] q);
    if (q != '0 && (q == cdb0_tag_in || q == cdb1_tag_in))
      snoop_q = '0;
    else
      snoop_q = q;
  endfunction

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel      = '0;
    w_free_vld = 1'b0;
    w_free     = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (r_busy[i] && r_qj[i] == '0 && r_qk[i] == '0) begin
        w_sel_vld = 1'b1;
        w_sel     = IW'(i);
      end
      if (!r_busy[i]) begin
        w_free_vld = 1'b1;
        w_free     = IW'(i);
      end
    end
  end

  assign w_full   = (r_count == CW'(RS_SIZE));
  assign w_accept = dsp_valid_in && !w_full && w_free_vld;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy     <= '0;
      r_count    <= '0;
      r_alu_op   <= NOP;
      r_alu_vj   <= '0;
      r_alu_vk   <= '0;
      r_alu_a    <= '0;
      r_alu_dest <= '0;
      r_alu_pc   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]   <= NOP;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_a[i]    <= '0;
        r_dest[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        r_busy     <= '0;
        r_count    <= '0;
        r_alu_op   <= NOP;
        r_alu_vj   <= '0;
        r_alu_vk   <= '0;
        r_alu_a    <= '0;
        r_alu_dest <= '0;
        r_alu_pc   <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i]) begin
            r_vj[i] <= snoop_v(r_qj[i], r_vj[i]);
            r_qj[i] <= snoop_q(r_qj[i]);
            r_vk[i] <= snoop_v(r_qk[i], r_vk[i]);
            r_qk[i] <= snoop_q(r_qk[i]);
          end
        end
        if (w_sel_vld) begin
          r_busy[w_sel] <= 1'b0;
          r_alu_op      <= r_op[w_sel];
          r_alu_vj      <= r_vj[w_sel];
          r_alu_vk      <= r_vk[w_sel];
          r_alu_a       <= r_a[w_sel];
          r_alu_dest    <= r_dest[w_sel];
          r_alu_pc      <= r_pc[w_sel];
        end else begin
          r_alu_op   <= NOP;
          r_alu_vj   <= '0;
          r_alu_vk   <= '0;
          r_alu_a    <= '0;
          r_alu_dest <= '0;
          r_alu_pc   <= '0;
        end
        // the free slot is non-busy, so it never collides with the issue slot
        if (w_accept) begin
          r_busy[w_free] <= 1'b1;
          r_op[w_free]   <= dsp_opcode_in;
          r_vj[w_free]   <= snoop_v(dsp_qj_in, dsp_vj_in);
          r_qj[w_free]   <= snoop_q(dsp_qj_in);
          r_vk[w_free]   <= snoop_v(dsp_qk_in, dsp_vk_in);
          r_qk[w_free]   <= snoop_q(dsp_qk_in);
          r_a[w_free]    <= dsp_a_in;
          r_dest[w_free] <= dsp_dest_in;
          r_pc[w_free]   <= dsp_pc_in;
        end
        r_count <= r_count + CW'(w_accept) - CW'(w_sel_vld);
      end
    end
  end

  assign rs_full_out    = w_full;
  assign rs_count_out   = r_count;
  assign alu_opcode_out = r_alu_op;
  assign alu_vj_out     = r_alu_vj;
  assign alu_vk_out     = r_alu_vk;
  assign alu_a_out      = r_alu_a;
  assign alu_dest_out   = r_alu_dest;
  assign alu_pc_out     = r_alu_pc;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Randomised scoreboard bench for alu_rs_scheduler against a
// behavioural station model kept in the bench.
module tb_alu_rs_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in;
  logic        dsp_valid_in;
  logic [5:0]  dsp_opcode_in;
  logic [31:0] dsp_vj_in, dsp_vk_in, dsp_a_in, dsp_pc_in;
  logic [3:0]  dsp_qj_in, dsp_qk_in, dsp_dest_in;
  logic [3:0]  cdb0_tag_in, cdb1_tag_in;
  logic [31:0] cdb0_val_in, cdb1_val_in;
  logic        flush_in;
  logic        rs_full_out;
  logic [4:0]  rs_count_out;
  logic [5:0]  alu_opcode_out;
  logic [31:0] alu_vj_out, alu_vk_out, alu_a_out, alu_pc_out;
  logic [3:0]  alu_dest_out;

  alu_rs_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dsp_valid_in(dsp_valid_in), .dsp_opcode_in(dsp_opcode_in),
    .dsp_vj_in(dsp_vj_in), .dsp_vk_in(dsp_vk_in),
    .dsp_qj_in(dsp_qj_in), .dsp_qk_in(dsp_qk_in),
    .dsp_a_in(dsp_a_in), .dsp_dest_in(dsp_dest_in),
    .dsp_pc_in(dsp_pc_in),
    .cdb0_tag_in(cdb0_tag_in), .cdb1_tag_in(cdb1_tag_in),
    .cdb0_val_in(cdb0_val_in), .cdb1_val_in(cdb1_val_in),
    .flush_in(flush_in), .rs_full_out(rs_full_out),
    .rs_count_out(rs_count_out), .alu_opcode_out(alu_opcode_out),
    .alu_vj_out(alu_vj_out), .alu_vk_out(alu_vk_out),
    .alu_a_out(alu_a_out), .alu_dest_out(alu_dest_out),
    .alu_pc_out(alu_pc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk, a, pc;
    logic [3:0]  dest;
    int          edge_n;
  } item_t;

  item_t exp_q[$];
  item_t m_out;

  bit [15:0]   m_busy;
  logic [5:0]  m_op[16];
  logic [31:0] m_vj[16], m_vk[16], m_a[16], m_pc[16];
  logic [3:0]  m_qj[16], m_qk[16], m_dest[16];
  int          m_count;

  int n_total = 0;
  int n_pass  = 0;
  int edge_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)",
                  name, act, exp, edge_cnt);
  endtask

  // operand capture rule: a pending tag picks up its value from a bus
  task automatic wake(inout logic [3:0] q, inout logic [31:0] v);
    if (q != 0) begin
      if (q == cdb0_tag_in) begin v = cdb0_val_in; q = 0; end
      else if (q == cdb1_tag_in) begin v = cdb1_val_in; q = 0; end
    end
  endtask

  task automatic model_reset();
    m_busy  = '0;
    m_count = 0;
    m_out   = '{op: 0, vj: 0, vk: 0, a: 0, pc: 0, dest: 0, edge_n: 0};
    exp_q.delete();
  endtask

  task automatic model_step();
    int sel, fr;
    bit acc;
    logic [3:0]  q;
    logic [31:0] v;
    item_t it;
    if (!rdy_in) begin
      if (m_out.op != 0) begin
        it = m_out;
        it.edge_n = edge_cnt + 1;
        exp_q.push_back(it);
      end
      return;
    end
    if (flush_in) begin
      m_busy  = '0;
      m_count = 0;
      m_out.op = 0;
      return;
    end
    sel = -1;
    fr  = -1;
    for (int i = 0; i < 16; i++) begin
      if (sel < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) sel = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    acc = dsp_valid_in && (m_count < 16);
    for (int i = 0; i < 16; i++) begin
      if (m_busy[i]) begin
        q = m_qj[i]; v = m_vj[i]; wake(q, v); m_qj[i] = q; m_vj[i] = v;
        q = m_qk[i]; v = m_vk[i]; wake(q, v); m_qk[i] = q; m_vk[i] = v;
      end
    end
    if (sel >= 0) begin
      it = '{op: m_op[sel], vj: m_vj[sel], vk: m_vk[sel], a: m_a[sel],
             pc: m_pc[sel], dest: m_dest[sel], edge_n: edge_cnt + 1};
      exp_q.push_back(it);
      m_out = it;
      m_busy[sel] = 1'b0;
      m_count--;
    end else begin
      m_out.op = 0;
    end
    if (acc) begin
      m_busy[fr] = 1'b1;
      m_op[fr] = dsp_opcode_in;
      m_a[fr] = dsp_a_in;
      m_pc[fr] = dsp_pc_in;
      m_dest[fr] = dsp_dest_in;
      q = dsp_qj_in; v = dsp_vj_in; wake(q, v); m_qj[fr] = q; m_vj[fr] = v;
      q = dsp_qk_in; v = dsp_vk_in; wake(q, v); m_qk[fr] = q; m_vk[fr] = v;
      m_count++;
    end
  endtask

  always @(posedge clk_in) begin
    item_t e;
    #1;
    edge_cnt++;
    if (alu_opcode_out !== 6'd0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_issue", 64'(alu_opcode_out), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_edge", 64'(edge_cnt), 64'(e.edge_n));
        chk("issue_op",   64'(alu_opcode_out), 64'(e.op));
        chk("issue_vj",   64'(alu_vj_out),     64'(e.vj));
        chk("issue_vk",   64'(alu_vk_out),     64'(e.vk));
        chk("issue_a",    64'(alu_a_out),      64'(e.a));
        chk("issue_dest", 64'(alu_dest_out),   64'(e.dest));
        chk("issue_pc",   64'(alu_pc_out),     64'(e.pc));
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt) begin
      e = exp_q.pop_front();
      chk("issue_missing", 64'(alu_opcode_out), 64'(e.op));
    end
    chk("count", 64'(rs_count_out), 64'(m_count));
    chk("full",  64'(rs_full_out),  64'(m_count == 16));
  end

  task automatic idle();
    rdy_in = 1; flush_in = 0; dsp_valid_in = 0;
    dsp_opcode_in = 0; dsp_vj_in = 0; dsp_vk_in = 0;
    dsp_qj_in = 0; dsp_qk_in = 0; dsp_a_in = 0;
    dsp_dest_in = 0; dsp_pc_in = 0;
    cdb0_tag_in = 0; cdb1_tag_in = 0;
    cdb0_val_in = 0; cdb1_val_in = 0;
  endtask

  task automatic disp(logic [5:0] op, logic [31:0] vj, logic [31:0] vk,
                      logic [3:0] qj, logic [3:0] qk, logic [3:0] dest,
                      logic [31:0] pc);
    dsp_valid_in = 1; dsp_opcode_in = op;
    dsp_vj_in = vj; dsp_vk_in = vk; dsp_qj_in = qj; dsp_qk_in = qk;
    dsp_a_in = pc ^ 32'h5A5A_0000; dsp_dest_in = dest; dsp_pc_in = pc;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk_in);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      idle();
      tick();
    end
  endtask

  task automatic do_reset();
    idle();
    rst_in = 0;
    model_reset();
    #1;
    chk("rst_opcode", 64'(alu_opcode_out), 64'd0);
    chk("rst_dest",   64'(alu_dest_out),   64'd0);
    chk("rst_count",  64'(rs_count_out),   64'd0);
    chk("rst_full",   64'(rs_full_out),    64'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1;
  endtask

  initial begin
    idle();
    #2;
    do_reset();

    // operand-ready ADD
    disp(6'd1, 32'd5, 32'd7, 0, 0, 4'd3, 32'h100);
    tick();
    ticks(4);

    // same-cycle bypass on cdb1, then a later qk wakeup on cdb0
    disp(6'd2, 32'd0, 32'd1, 4'd4, 0, 4'd1, 32'h200);
    cdb1_tag_in = 4'd4; cdb1_val_in = 32'hDEAD;
    tick();
    idle();
    disp(6'd3, 32'd9, 32'd0, 0, 4'd6, 4'd2, 32'h204);
    tick();
    ticks(1);
    idle();
    cdb0_tag_in = 4'd6; cdb0_val_in = 32'hBEEF;
    cdb1_tag_in = 4'd6; cdb1_val_in = 32'h1111;
    tick();
    ticks(4);

    // entries 2 and 9 woken together
    for (int i = 0; i < 10; i++) begin
      idle();
      disp(6'(10 + i), 32'(i), 32'(i * 3), (i == 2 || i == 9) ? 4'd8 : 4'd9,
           0, 4'd5, 32'h300 + 32'(i));
      tick();
    end
    idle();
    cdb0_tag_in = 4'd8; cdb0_val_in = 32'h88;
    tick();
    ticks(3);

    // flush beats dispatch and a ready entry
    disp(6'd30, 32'd1, 32'd2, 0, 0, 4'd6, 32'h400);
    tick();
    idle();
    disp(6'd31, 32'd3, 32'd4, 0, 0, 4'd7, 32'h404);
    flush_in = 1;
    tick();
    ticks(4);

    // fill to 16, drop the 17th, then drain in index order
    for (int i = 0; i < 17; i++) begin
      idle();
      disp(6'(i + 1), 32'(i), 32'(100 + i), 4'd5, 0,
           4'(1 + (i % 15)), 32'h500 + 32'(i * 4));
      tick();
    end
    ticks(1);
    idle();
    cdb0_tag_in = 4'd5; cdb0_val_in = 32'h55;
    tick();
    ticks(18);

    // stall with CDB activity
    disp(6'd40, 32'd0, 32'd2, 4'd3, 0, 4'd8, 32'h600);
    tick();
    idle();
    disp(6'd41, 32'd6, 32'd7, 0, 0, 4'd9, 32'h604);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      rdy_in = 0;
      cdb0_tag_in = 4'd3; cdb0_val_in = 32'h33;
      disp(6'd42, 32'd0, 32'd0, 0, 0, 4'd1, 32'h608);
      tick();
    end
    ticks(4);
    idle();
    cdb1_tag_in = 4'd3; cdb1_val_in = 32'h77;
    tick();
    ticks(3);

    // async reset with 5 busy entries and an op on the outputs
    for (int i = 0; i < 5; i++) begin
      idle();
      disp(6'd50, 32'd0, 32'd0, 4'd2, 0, 4'd3, 32'h700 + 32'(i));
      tick();
    end
    idle();
    disp(6'd51, 32'd1, 32'd1, 0, 0, 4'd4, 32'h720);
    tick();
    ticks(1);
    #2;
    do_reset();
    ticks(5);
    disp(6'd52, 32'd8, 32'd9, 0, 0, 4'd5, 32'h730);
    tick();
    ticks(3);

    // randomised traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      rdy_in   = ($urandom_range(0, 19) != 0);
      flush_in = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) != 0)
        disp(6'($urandom_range(1, 63)), $urandom, $urandom,
             ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0,
             ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0,
             4'($urandom_range(1, 15)), $urandom);
      cdb0_tag_in = 4'($urandom_range(0, 15));
      cdb1_tag_in = 4'($urandom_range(0, 15));
      cdb0_val_in = $urandom;
      cdb1_val_in = $urandom;
      tick();
    end

    for (int t = 1; t < 16; t++) begin
      idle();
      cdb0_tag_in = 4'(t); cdb0_val_in = $urandom;
      tick();
    end
    ticks(20);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_count", 64'(rs_count_out), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
